// File: rtl/cfs_apb_pkg.sv
// Shared types and constants for the APB initiator and the Aligner register map.
package cfs_apb_pkg;

  localparam int unsigned APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } cfs_apb_master_state_t;

  // Aligner register file byte addresses
  localparam logic [15:0] ADDR_CTRL   = 16'h0000;
  localparam logic [15:0] ADDR_STATUS = 16'h000C;
  localparam logic [15:0] ADDR_IRQEN  = 16'h00F0;
  localparam logic [15:0] ADDR_IRQ    = 16'h00F4;

endpackage

// File: rtl/cfs_apb_master.sv
// APB3 initiator: one valid/ready request becomes one SETUP/ACCESS transfer,
// with an optional pready timeout and a held valid/ready response.
module cfs_apb_master #(
  parameter int unsigned APB_ADDR_WIDTH = 16,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT        = 32
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic                      pready,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pslverr
);
  import cfs_apb_pkg::*;

  localparam int unsigned CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_SAT  = (TIMEOUT == 0) ? 1 : TIMEOUT;
  localparam int unsigned CNT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam bit          TO_EN    = (TIMEOUT != 0);

  cfs_apb_master_state_t state, state_nxt;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  req_fire;
  logic                  rsp_fire;
  logic                  xfer_done;
  logic                  xfer_timeout;

  assign req_fire  = req_ready && req_valid;
  assign rsp_fire  = (state == RESP) && rsp_ready;
  assign xfer_done = (state == ACCESS) && pready;
  // Abort on the cycle whose missing pready would bring the count to TIMEOUT;
  // a pready on that same cycle takes the xfer_done path instead.
  assign xfer_timeout = TO_EN && (state == ACCESS) && !pready &&
                        (wait_cnt == CNT_W'(CNT_LAST));

  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_fire) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (xfer_done || xfer_timeout) state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Held off during reset so no request can be taken while preset is high.
  always_comb begin
    req_ready = (state == IDLE) && !preset;
    busy      = (state != IDLE);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      psel      <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      penable   <= (state_nxt == ACCESS);
      rsp_valid <= (state_nxt == RESP);

      if (req_fire) begin
        paddr  <= req_addr;
        pwrite <= req_write;
        pwdata <= req_wdata;
      end

      if (state == SETUP) begin
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !pready && (wait_cnt != CNT_W'(CNT_SAT))) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (xfer_done) begin
        rsp_rdata   <= (pwrite || pslverr) ? '0 : prdata;
        rsp_slverr  <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (xfer_timeout) begin
        rsp_rdata   <= '0;
        rsp_slverr  <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cfs_apb_master.sv
// Self-checking bench for cfs_apb_master: vector table plus response scoreboard.
module tb_cfs_apb_master;

  localparam int unsigned TO = 16;

  logic        pclk = 1'b0;
  logic        preset;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr, rsp_timeout, busy;
  logic [15:0] paddr;
  logic        pwrite, psel, penable;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  cfs_apb_master #(
    .APB_ADDR_WIDTH(16),
    .APB_DATA_WIDTH(32),
    .TIMEOUT       (TO)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .busy       (busy),
    .paddr      (paddr),
    .pwrite     (pwrite),
    .psel       (psel),
    .penable    (penable),
    .pwdata     (pwdata),
    .pready     (pready),
    .prdata     (prdata),
    .pslverr    (pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit          write;
    logic [15:0] addr;
    logic [31:0] wdata;
    int unsigned waits;     // ACCESS cycles with pready=0 before pready=1
    bit          err;
    bit          never_rdy;
    logic [31:0] rdata;
    int unsigned bp;        // extra cycles rsp_ready is held low
    logic [31:0] exp_rdata;
    bit          exp_slverr;
    bit          exp_timeout;
    int unsigned exp_psel;  // cycles with psel high
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          slverr;
    bit          timeout;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_psel"},        psel, 0);
    check({tag, "_penable"},     penable, 0);
    check({tag, "_pwrite"},      pwrite, 0);
    check({tag, "_paddr"},       paddr, 0);
    check({tag, "_pwdata"},      pwdata, 0);
    check({tag, "_rsp_valid"},   rsp_valid, 0);
    check({tag, "_rsp_rdata"},   rsp_rdata, 0);
    check({tag, "_rsp_slverr"},  rsp_slverr, 0);
    check({tag, "_rsp_timeout"}, rsp_timeout, 0);
    check({tag, "_busy"},        busy, 0);
    check({tag, "_req_ready"},   req_ready, 0);
  endtask

  function automatic vec_t mk(bit w, logic [15:0] a, logic [31:0] wd, int unsigned waits,
                              bit err, bit nr, logic [31:0] rd, int unsigned bp,
                              logic [31:0] erd, bit es, bit et, int unsigned epsel);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = wd; v.waits = waits; v.err = err;
    v.never_rdy = nr; v.rdata = rd; v.bp = bp; v.exp_rdata = erd;
    v.exp_slverr = es; v.exp_timeout = et; v.exp_psel = epsel;
    return v;
  endfunction

  task automatic check_rsp(input string tag, input exp_t e);
    check({tag, "_rsp_valid"},   rsp_valid, 1);
    check({tag, "_rsp_rdata"},   rsp_rdata, e.rdata);
    check({tag, "_rsp_slverr"},  rsp_slverr, e.slverr);
    check({tag, "_rsp_timeout"}, rsp_timeout, e.timeout);
  endtask

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic run_txn(input string tag, input vec_t v);
    int unsigned acc, pcyc, guard;
    bit          prev_psel, done;
    exp_t        e;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge pclk);
      guard++;
    end
    if (!req_ready) begin
      check({tag, "_req_ready_wait"}, req_ready, 1);
      return;
    end
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
    e.rdata = v.exp_rdata; e.slverr = v.exp_slverr; e.timeout = v.exp_timeout;
    exp_q.push_back(e);
    @(negedge pclk);
    req_valid = 1'b0;
    req_write = ~v.write;
    req_addr  = 16'($urandom);
    req_wdata = $urandom;
    acc = 0; pcyc = 0; prev_psel = 1'b0; done = 1'b0; guard = 0;
    while (!done && guard < 100) begin
      guard++;
      if (psel) begin
        pcyc++;
        if (penable) acc++;
        check({tag, "_paddr"},  paddr, v.addr);
        check({tag, "_pwrite"}, pwrite, v.write);
        check({tag, "_pwdata"}, pwdata, v.wdata);
      end
      if (rsp_valid) begin
        pready = 1'b0;
        check({tag, "_rsp_after_psel"}, prev_psel, 1);
        check({tag, "_psel_cycles"}, pcyc, v.exp_psel);
        if (exp_q.size() == 0) begin
          check({tag, "_scoreboard_empty"}, exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_rsp(tag, e);
          for (int unsigned i = 0; i < v.bp; i++) begin
            @(negedge pclk);
            check_rsp({tag, "_hold"}, e);
            check({tag, "_hold_req_ready"}, req_ready, 0);
            check({tag, "_hold_psel"}, psel, 0);
          end
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        check({tag, "_post_rsp_valid"}, rsp_valid, 0);
        check({tag, "_post_req_ready"}, req_ready, 1);
        check({tag, "_post_busy"}, busy, 0);
        done = 1'b1;
      end else begin
        if (psel && !penable) begin
          // pready/pslverr outside ACCESS must be ignored
          pready = 1'b1; pslverr = 1'b1; prdata = 32'hBADC0DE0;
        end else if (psel && penable && !v.never_rdy && acc == v.waits + 1) begin
          pready = 1'b1; pslverr = v.err; prdata = v.rdata;
        end else begin
          pready = 1'b0; pslverr = 1'b1; prdata = 32'hDEADBEEF;
        end
        prev_psel = psel;
        @(negedge pclk);
      end
    end
    if (!done) check({tag, "_rsp_budget"}, rsp_valid, 1);
    pready = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    int unsigned acc, guard;
    preset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;

    //            w  addr     wdata         wt  er nr rdata         bp erd           es et psel
    vecs[0] = mk(0, 16'h000C, 32'h0,         1, 0, 0, 32'h00030205, 0, 32'h00030205, 0, 0, 3);
    vecs[1] = mk(1, 16'h0000, 32'h00000102,  0, 0, 0, 32'hDEADBEEF, 0, 32'h0,        0, 0, 2);
    vecs[2] = mk(0, 16'h0010, 32'h0,         0, 1, 0, 32'h12345678, 0, 32'h0,        1, 0, 2);
    vecs[3] = mk(1, 16'h0000, 32'h00000055,  2, 1, 0, 32'h0,        0, 32'h0,        1, 0, 4);
    vecs[4] = mk(0, 16'h00F4, 32'h0,         0, 0, 1, 32'h0,        0, 32'h0,        1, 1, TO + 1);
    vecs[5] = mk(0, 16'h00F0, 32'h0,        15, 0, 0, 32'h0000A5A5, 0, 32'h0000A5A5, 0, 0, TO + 1);
    vecs[6] = mk(1, 16'h00F0, 32'h0000000F,  0, 0, 0, 32'h0,        5, 32'h0,        0, 0, 2);
    vecs[7] = mk(0, 16'h000C, 32'h0,         3, 0, 0, 32'h00000077, 2, 32'h00000077, 0, 0, 5);
    vecs[8] = mk(0, 16'h00F4, 32'h0,        14, 0, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 0, TO);

    repeat (3) @(negedge pclk);
    check_all_zero("reset");
    preset = 1'b0;
    @(negedge pclk);
    check("release_req_ready", req_ready, 1);
    check("release_busy", busy, 0);

    for (int i = 0; i < 9; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Reset in the 2nd ACCESS cycle: no response may follow.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h000C; req_wdata = 32'h11223344;
    @(negedge pclk);
    req_valid = 1'b0;
    acc = 0; guard = 0;
    while (acc < 2 && guard < 20) begin
      guard++;
      if (psel && penable) acc++;
      if (acc < 2) begin
        pready = 1'b0;
        @(negedge pclk);
      end
    end
    check("midreset_access_reached", acc, 2);
    preset = 1'b1;
    @(negedge pclk);
    check_all_zero("midreset");
    preset = 1'b0;
    @(negedge pclk);
    check("midreset_req_ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("midreset_no_rsp", rsp_valid, 0);
      @(negedge pclk);
    end

    run_txn("after_reset", vecs[0]);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cfs_apb_master.md
# cfs_apb_master

APB initiator that turns single-word register requests into APB3 transfers toward the Aligner register file or any other APB responder in the design. It accepts one request at a time on a valid/ready request port and drives the setup and access phases. It waits for `pready`, with an optional timeout, and returns the read data and error status on a valid/ready response port. It sits between test or firmware-model logic and the `paddr`/`psel`/`penable` bus of the Aligner.

## Interface
- `APB_ADDR_WIDTH`, 16, APB address width.
- `APB_DATA_WIDTH`, 32, APB data width; fixed at 32.
- `TIMEOUT`, 32, maximum number of ACCESS cycles to wait for `pready`; 0 disables the timeout.

Ports:
- `pclk` input 1: single clock. Everything is clocked on its rising edge.
- `preset` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted on this cycle when `req_valid` is also high.
- `req_write` input 1: 1 = write, 0 = read.
- `req_addr` input APB_ADDR_WIDTH: byte address, passed to `paddr` unmodified.
- `req_wdata` input 32: write data.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: response consumed.
- `rsp_rdata` output 32: read data. It is 0 for writes, for timeouts, and for reads that complete with `pslverr`=1.
- `rsp_slverr` output 1: `pslverr` sampled on completion, or 1 on timeout.
- `rsp_timeout` output 1: the transfer was aborted by the timeout.
- `busy` output 1: high whenever the state is not IDLE.
- `paddr` output APB_ADDR_WIDTH.
- `pwrite` output 1.
- `psel` output 1.
- `penable` output 1.
- `pwdata` output 32.
- `pready` input 1.
- `prdata` input 32.
- `pslverr` input 1.

## Operation
The state machine has four states: IDLE, SETUP, ACCESS and RESP.

IDLE:
- `req_ready`=1 in this state.
- A request handshake latches `req_write`, `req_addr` and `req_wdata` into `pwrite`, `paddr` and `pwdata`.
- The transition is to SETUP.

SETUP:
- `psel`=1, `penable`=0.
- Always lasts exactly one cycle, then moves to ACCESS.

ACCESS:
- `psel`=1, `penable`=1.
- `paddr`, `pwrite` and `pwdata` stay stable throughout.
- The wait counter is cleared on entry and incremented each cycle that `pready`=0.
- On `pready`=1:
  - Capture `prdata` (reads only) and `pslverr`.
  - Move to RESP.
- If `TIMEOUT`≠0 and the counter reaches `TIMEOUT` with `pready` still 0:
  - Abort the transfer.
  - Load `rsp_slverr`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - Move to RESP.

RESP:
- `psel`=0, `penable`=0.
- `rsp_valid`=1, and the response stays stable until `rsp_ready`=1.
- After the response handshake, return to IDLE.
- There is no RESP→SETUP shortcut, so back-to-back requests are separated by at least one IDLE cycle.

General rules:
- The counter width is `$clog2(TIMEOUT+1)`; the counter saturates and never wraps.
- `pready` is ignored outside ACCESS.
- A `pready` arriving on the same cycle the counter reaches `TIMEOUT` wins: the transfer completes normally.
- `paddr`, `pwrite` and `pwdata` hold their last values in IDLE and RESP.

Reset:
- Reset values: every output is 0 (`psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `rsp_*`, `busy`, `req_ready`), and the state is IDLE.
- `req_ready` goes to 1 on the first cycle after `preset` deasserts.
- Reset asserted in any state, including mid-ACCESS, forces the reset values at the next edge. No response is produced for the interrupted transfer.

## Timing
- All outputs are registered except `req_ready` and `busy`, which are decoded from the state.
- Request handshake at edge N:
  - SETUP is visible in cycle N+1.
  - ACCESS is visible in cycle N+2.
- With `pready` sampled high at edge M, `rsp_valid` is 1 in cycle M+1.
- Minimum request-to-response latency is 3 cycles: SETUP, one ACCESS cycle, then RESP.
- Minimum spacing between request accepts is 4 cycles.
- With no wait states, the timeout response appears `TIMEOUT`+1 cycles after entering ACCESS.

## Structure
- Shared package `cfs_apb_pkg`:
  - State enum `cfs_apb_master_state_t` with values IDLE, SETUP, ACCESS, RESP.
  - `APB_DATA_WIDTH`=32.
  - The Aligner register address constants: CTRL 0x0000, STATUS 0x000C, IRQEN 0x00F0, IRQ 0x00F4.
- No sub-module: the block is a single state machine, the wait counter and the response holding registers.

## Test plan
- Read STATUS: request read 0x000C; responder gives `pready` on the 2nd ACCESS cycle with `prdata`=0x00030205. Required: `rsp_rdata`=0x00030205, `rsp_slverr`=0, `psel` high for exactly 3 cycles.
- Write CTRL: request write 0x0000, wdata 0x00000102, zero-wait responder. Required: `pwdata`=0x00000102 in SETUP and ACCESS, `rsp_slverr`=0, `rsp_rdata`=0.
- Unmapped and error completions:
  - Read 0x0010 with `pslverr`=1 → `rsp_slverr`=1, `rsp_timeout`=0.
  - Write 0x0000 with 2 wait cycles then `pslverr`=1 → `rsp_slverr`=1.
- Timeout with `TIMEOUT`=16 and `pready` held 0. Required:
  - Exactly 16 ACCESS cycles, then `psel`=0.
  - `rsp_timeout`=1, `rsp_slverr`=1, `rsp_rdata`=0.
  - A repeat run with `pready`=1 on the 16th cycle completes normally.
- Backpressure: hold `rsp_ready`=0 for 5 cycles. Required: the response is stable, `req_ready`=0 and `psel`=0 throughout; the next request is accepted 1 cycle after the response handshake.
- Reset mid-ACCESS: assert `preset` in the 2nd ACCESS cycle. Required: all outputs 0 at the next edge, no `rsp_valid`, and `req_ready`=1 in the first cycle after release.
